// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the custom_alu issue controller: opcodes, requester IDs
// and the controller state encodings.
package alu_issue_ctrl_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_NAV  = 1'b1;

  localparam logic [1:0] IC_IDLE  = 2'd0;
  localparam logic [1:0] IC_ISSUE = 2'd1;
  localparam logic [1:0] IC_WAIT  = 2'd2;
  localparam logic [1:0] IC_RESP  = 2'd3;

endpackage

// File: rtl/alu_issue_ctrl_pick.sv
// Requester pick for the ALU issue controller. The navigation unit wins ties
// unless the core has been passed over STARVE_LIMIT times in a row.
module alu_issue_pick
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic r0_valid,
  input  logic r1_valid,
  input  logic grant,
  output logic grant_id,
  output logic any_req
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  // Priority pick: requester 1 first, requester 0 once starvation is reached
  always_comb begin
    starved  = r0_valid && (starve_cnt == CW'(STARVE_LIMIT));
    any_req  = r0_valid || r1_valid;
    grant_id = (r1_valid && !starved) ? REQ_NAV : REQ_CORE;
  end

  // Count requester 1 grants taken while requester 0 waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!r0_valid) begin
      starve_cnt <= '0;
    end else if (grant) begin
      starve_cnt <= (grant_id == REQ_NAV) ? starve_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared custom_alu: arbitrates two requesters, issues
// one op at a time, waits out the ALU latency and returns a tagged response.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned W            = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [4:0]   r0_opcode,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [4:0]   r1_opcode,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_neg,
  output logic         resp_err,
  output logic [4:0]   alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_valid
);

  logic [1:0] state;
  logic       req_id;
  logic       grant;
  logic       grant_id;
  logic       any_req;

  alu_issue_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .r0_valid (r0_valid),
    .r1_valid (r1_valid),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // Accept strobes: only in IDLE, only for the picked requester; forced low in reset
  always_comb begin
    grant    = rst_n && (state == IC_IDLE) && any_req;
    r0_ready = grant && (grant_id == REQ_CORE);
    r1_ready = grant && (grant_id == REQ_NAV);
  end

  // Issue sequencing and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IC_IDLE;
      req_id      <= REQ_CORE;
      alu_opcode  <= OP_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_neg    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (grant) begin
            alu_opcode <= (grant_id == REQ_NAV) ? r1_opcode : r0_opcode;
            alu_a      <= (grant_id == REQ_NAV) ? r1_a : r0_a;
            alu_b      <= (grant_id == REQ_NAV) ? r1_b : r0_b;
            req_id     <= grant_id;
            state      <= IC_ISSUE;
          end
        end
        IC_ISSUE: begin
          // The ALU samples the held op on this edge; park it on NOP afterwards
          alu_opcode <= OP_NOP;
          alu_a      <= '0;
          alu_b      <= '0;
          state      <= IC_WAIT;
        end
        IC_WAIT: begin
          // Flags come from the captured result, not the ALU's lagging flags
          resp_result <= alu_result;
          resp_err    <= ~alu_valid;
          resp_zero   <= (alu_result == '0);
          resp_neg    <= alu_result[W-1];
          resp_id     <= req_id;
          resp_valid  <= 1'b1;
          state       <= IC_RESP;
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IC_IDLE;
          end
        end
      endcase
    end
  end

  // A requester must hold its op until it is accepted
  a_r0_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (r0_valid && !r0_ready) |=> r0_valid);
  a_r1_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (r1_valid && !r1_ready) |=> r1_valid);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small registered custom_alu model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [4:0]   r0_opcode, r1_opcode;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         resp_valid, resp_ready, resp_id, resp_zero, resp_neg, resp_err;
  logic [W-1:0] resp_result;
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_result = '0;
  logic         alu_valid  = 1'b1;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.STARVE_LIMIT(4), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_err(resp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_valid(alu_valid)
  );

  always #5 clk = ~clk;

  // custom_alu model: one-cycle registered result, valid low on unknown opcodes
  always @(posedge clk) begin
    case (alu_opcode)
      OP_NOP:  begin alu_result <= '0;            alu_valid <= 1'b1; end
      OP_ADD:  begin alu_result <= alu_a + alu_b; alu_valid <= 1'b1; end
      OP_SUB:  begin alu_result <= alu_a - alu_b; alu_valid <= 1'b1; end
      default: begin alu_result <= '0;            alu_valid <= 1'b0; end
    endcase
  end

  // Stimulus only: present one op, wait for accept and response, collect the response.
  // Called just after a negedge; returns just after a negedge with the controller in IDLE.
  task automatic run_op(input logic id, input logic [4:0] op, input logic [W-1:0] a, b,
                        output logic [W-1:0] res, output logic rid, z, n, e,
                        output int lat, output bit to);
    int k;
    to = 0; lat = 0; k = 0;
    res = '0; rid = 0; z = 0; n = 0; e = 0;
    if (id) begin r1_valid = 1; r1_opcode = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1; r0_opcode = op; r0_a = a; r0_b = b; end
    #1;
    while (!(id ? r1_ready : r0_ready) && k < 20) begin @(negedge clk); #1; k++; end
    if (k >= 20) begin
      to = 1; r0_valid = 0; r1_valid = 0;
    end else begin
      @(posedge clk); #1;
      r0_valid = 0; r1_valid = 0;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!resp_valid) to = 1;
      res = resp_result; rid = resp_id; z = resp_zero; n = resp_neg; e = resp_err;
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", r0_ready, r1_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_result !== '0 || resp_id !== 1'b0) begin failures++; $display("FAIL reset_resp_data got=%h/%b exp=0000/0", resp_result, resp_id); end
    checks++; if ({resp_zero, resp_neg, resp_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {resp_zero, resp_neg, resp_err}); end
    checks++; if (alu_opcode !== OP_NOP) begin failures++; $display("FAIL reset_alu_op got=%h exp=%h", alu_opcode, OP_NOP); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin failures++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
    @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] res; logic rid, z, n, e; int lat; bit to;
    run_op(REQ_CORE, OP_ADD, 16'd5, 16'd7, res, rid, z, n, e, lat, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    // accept edge plus two more edges = 3 clocks
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (res !== 16'd12) begin failures++; $display("FAIL basic_result got=%0d exp=12", res); end
    checks++; if ({rid, z, n, e} !== 4'b0000) begin failures++; $display("FAIL basic_id_flags got=%b exp=0000", {rid, z, n, e}); end
  endtask

  task automatic test_flags();
    logic [W-1:0] res; logic rid, z, n, e; int lat; bit to;
    run_op(REQ_NAV, OP_SUB, 16'd3, 16'd3, res, rid, z, n, e, lat, to);
    checks++; if (to || res !== 16'h0000) begin failures++; $display("FAIL sub_zero_result got=%h exp=0000", res); end
    checks++; if ({rid, z, n, e} !== 4'b1100) begin failures++; $display("FAIL sub_zero_flags got=%b exp=1100", {rid, z, n, e}); end
    run_op(REQ_NAV, OP_SUB, 16'd2, 16'd3, res, rid, z, n, e, lat, to);
    checks++; if (to || res !== 16'hFFFF) begin failures++; $display("FAIL sub_neg_result got=%h exp=ffff", res); end
    checks++; if ({rid, z, n, e} !== 4'b1010) begin failures++; $display("FAIL sub_neg_flags got=%b exp=1010", {rid, z, n, e}); end
  endtask

  task automatic test_starve();
    logic exp_order [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    logic gid;
    int   k;
    r0_valid = 1; r0_opcode = OP_ADD; r0_a = 16'd1; r0_b = 16'd1;
    r1_valid = 1; r1_opcode = OP_ADD; r1_a = 16'd2; r1_b = 16'd2;
    #1;
    for (int g = 0; g < 13; g++) begin
      k = 0;
      while (!(r0_ready || r1_ready) && k < 20) begin @(posedge clk); #1; k++; end
      if (k >= 20) begin
        checks++; failures++; $display("FAIL starve_grant_timeout got=none exp=grant%0d", g);
        break;
      end
      gid = r1_ready;
      if (g < 12) begin
        checks++; if (gid !== exp_order[g]) begin failures++; $display("FAIL starve_order[%0d] got=%b exp=%b", g, gid, exp_order[g]); end
      end
      @(posedge clk); #1;
      if (g == 11) r1_valid = 0;
      if (g == 12) r0_valid = 0;
      k = 0;
      while (!resp_valid && k < 20) begin @(posedge clk); #1; k++; end
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== gid || resp_result !== (gid ? 16'd4 : 16'd2)) begin
        failures++; $display("FAIL starve_resp[%0d] got=v%b id%b %0d exp=v1 id%b %0d", g, resp_valid, resp_id, resp_result, gid, gid ? 4 : 2);
      end
      @(posedge clk); #1;
    end
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [W-1:0] res; logic rid, z, n, e; int lat; bit to;
    run_op(REQ_CORE, 5'h1F, 16'd9, 16'd9, res, rid, z, n, e, lat, to);
    checks++; if (to || e !== 1'b1 || res !== '0) begin failures++; $display("FAIL err_flag got=err%b res%h exp=err1 res0000", e, res); end
    run_op(REQ_CORE, OP_ADD, 16'd20, 16'd22, res, rid, z, n, e, lat, to);
    checks++; if (to || e !== 1'b0 || res !== 16'd42 || lat != 2) begin failures++; $display("FAIL err_recover got=err%b res%0d lat%0d exp=err0 res42 lat2", e, res, lat); end
  endtask

  task automatic test_backpressure();
    int  k;
    resp_ready = 0;
    r1_valid = 1; r1_opcode = OP_ADD; r1_a = 16'h8000; r1_b = 16'h0001;
    #1; k = 0;
    while (!r1_ready && k < 20) begin @(negedge clk); #1; k++; end
    @(posedge clk); #1; r1_valid = 0;
    k = 0;
    while (!resp_valid && k < 20) begin @(posedge clk); #1; k++; end
    r0_valid = 1; r0_opcode = OP_ADD; r0_a = 16'd1; r0_b = 16'd2;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 16'h8001 || resp_id !== 1'b1 ||
          {resp_zero, resp_neg, resp_err} !== 3'b010 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=v%b %h id%b zne%b rdy%b%b exp=v1 8001 id1 zne010 rdy00",
                 c, resp_valid, resp_result, resp_id, {resp_zero, resp_neg, resp_err}, r0_ready, r1_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || r0_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=v%b r0rdy%b exp=v0 r0rdy1", resp_valid, r0_ready); end
    @(posedge clk); #1; r0_valid = 0;
    k = 0;
    while (!resp_valid && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (resp_valid !== 1'b1 || resp_result !== 16'd3 || resp_id !== 1'b0) begin failures++; $display("FAIL bp_next got=v%b %0d id%b exp=v1 3 id0", resp_valid, resp_result, resp_id); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res; logic rid, z, n, e; int lat; bit to;
    int k;
    r0_valid = 1; r0_opcode = OP_ADD; r0_a = 16'd4; r0_b = 16'd4;
    #1; k = 0;
    while (!r0_ready && k < 20) begin @(negedge clk); #1; k++; end
    @(posedge clk); #1; r0_valid = 0;   // ISSUE
    @(posedge clk); #2;                 // WAIT
    rst_n = 0; #1;
    checks++;
    if (resp_valid !== 1'b0 || alu_opcode !== OP_NOP || alu_a !== '0 || alu_b !== '0 ||
        r0_ready !== 1'b0 || r1_ready !== 1'b0 || resp_result !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=v%b op%h a%h b%h rdy%b%b res%h exp=all zero",
               resp_valid, alu_opcode, alu_a, alu_b, r0_ready, r1_ready, resp_result);
    end
    @(negedge clk); @(negedge clk); rst_n = 1;
    k = 0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (resp_valid !== 1'b0) k++; end
    checks++; if (k != 0) begin failures++; $display("FAIL rst_mid_stale got=%0d exp=0 cycles with resp_valid", k); end
    @(negedge clk);
    run_op(REQ_NAV, OP_SUB, 16'd10, 16'd3, res, rid, z, n, e, lat, to);
    checks++; if (to || res !== 16'd7 || rid !== 1'b1 || lat != 2) begin failures++; $display("FAIL rst_mid_next got=%0d id%b lat%0d exp=7 id1 lat2", res, rid, lat); end
  endtask

  initial begin
    rst_n = 0; resp_ready = 1;
    r0_valid = 0; r0_opcode = OP_NOP; r0_a = '0; r0_b = '0;
    r1_valid = 0; r1_opcode = OP_NOP; r1_a = '0; r1_b = '0;
    test_reset();
    test_basic();
    test_flags();
    test_starve();
    test_err();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequences the shared custom_alu between two requesters: requester 0 (general-purpose control core) and requester 1 (navigation/obstacle unit). Arbitrates, issues one operation at a time, and waits out the ALU's one-cycle latency. Captures the result and returns it, tagged with the requester ID, over a single valid/ready response channel. Sits between the decode stage, the navigation unit and custom_alu.

Parameters:
STARVE_LIMIT, 4, max consecutive grants to requester 1 while requester 0 is pending; the next grant is then forced to requester 0.
W, 16, operand/result width; must match custom_alu.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
r0_valid  in  1  requester 0 has an op
r0_ready  out  1  requester 0 op accepted this cycle
r0_opcode  in  5  requester 0 opcode (defines.v encoding)
r0_a  in  W  requester 0 operand A
r0_b  in  W  requester 0 operand B
r1_valid  in  1  requester 1 has an op
r1_ready  out  1  requester 1 op accepted this cycle
r1_opcode  in  5  requester 1 opcode
r1_a  in  W  requester 1 operand A
r1_b  in  W  requester 1 operand B
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  1  requester that issued the op
resp_result  out  W  ALU result
resp_zero  out  1  resp_result == 0
resp_neg  out  1  resp_result[W-1]
resp_err  out  1  ALU flagged the opcode invalid (valid_out low)
alu_opcode  out  5  to custom_alu opcode
alu_a  out  W  to custom_alu A
alu_b  out  W  to custom_alu B
alu_result  in  W  from custom_alu result
alu_valid  in  1  from custom_alu valid_out

Behaviour:
- Reset: state IDLE. r0_ready=r1_ready=0, resp_* all 0, alu_opcode=OP_NOP, alu_a=alu_b=0, starve counter=0. Reset mid-operation abandons the in-flight op; no response is produced.
- r*_ready are combinational: asserted only in IDLE for the granted requester; at most one is high per cycle.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any valid, grant. Requester 1 wins ties unless starve counter == STARVE_LIMIT and r0_valid, in which case requester 0 wins. On the accept edge, register opcode/A/B onto alu_* and store the ID. Go to ISSUE.
- Starve counter: increments on a requester 1 grant while r0_valid is high. Clears on any requester 0 grant and whenever r0_valid is low.
- ISSUE: alu_* held; custom_alu registers the op at the end of this cycle. Go to WAIT.
- WAIT: alu_result/alu_valid now reflect the issued op. Capture resp_result=alu_result, resp_err=~alu_valid. Compute resp_zero and resp_neg from the captured result itself; custom_alu's own flags lag one op and are not used. Drive alu_opcode=OP_NOP. Go to RESP with resp_valid=1.
- RESP: hold all resp_* stable until resp_valid&&resp_ready, then resp_valid=0 and go to IDLE. No new grant in this cycle.
- Latency: accept edge to resp_valid high = 3 clocks. Max throughput is one op per 4 cycles with resp_ready tied high.
- alu_* are held at OP_NOP/0 in IDLE and RESP, so custom_alu produces result 0 with valid 1 between ops.
- A requester dropping valid before ready is a protocol violation; behaviour is unspecified and flagged by an assertion.

Decomposition:
- defines.v gains: REQ_CORE=1'b0, REQ_NAV=1'b1, and 2-bit FSM state encodings IC_IDLE/IC_ISSUE/IC_WAIT/IC_RESP. Opcodes come from the existing OP_* defines.
- One sub-module, alu_issue_pick: combinational priority pick plus starvation counter. Inputs: r0_valid, r1_valid, grant strobe. Outputs: grant_id and any_req.

Test Plan:
- r0 only, OP_ADD A=5 B=7, resp_ready=1 -> r0_ready one cycle; 3 clocks later resp_valid=1, resp_id=0, resp_result=12, zero=0, neg=0, err=0.
- r1 OP_SUB A=3 B=3 -> result 0, zero=1. Immediately follow with r1 OP_SUB A=2 B=3 -> result 16'hFFFF, neg=1, zero=0. Checks flags are not stale.
- r0 and r1 both held valid for 12 ops, STARVE_LIMIT=4 -> grant order 1,1,1,1,0,1,1,1,1,0,1,1.
- r0 opcode 5'h1F (unassigned in defines.v) -> resp_err=1, resp_result=0. Controller returns to IDLE and the next op completes normally.
- resp_ready held low for 10 cycles during RESP -> resp_* stable, r0_ready/r1_ready stay 0 throughout, grant occurs on the cycle after the handshake.
- rst_n asserted during WAIT -> all outputs zero/OP_NOP immediately (async). After release the first op completes with correct result and no stale response.
